bram_burst_scheduler: RTL and testbench

Round-robin scheduler that shares one BRAM address generator between several burst requesters in the transpose-convolution datapath, e.g. the weight loader, the ifmap loader and the ofmap writer. Each requester posts a start address and a burst length. The scheduler grants one requester at a time and configures the generic address counter for that burst. It then issues one BRAM address per un-stalled cycle and signals burst completion back to the granted requester.

---
 rtl/bram_burst_scheduler_pkg.sv | 18 +
 rtl/axis_counter.sv | 48 ++++
 rtl/bram_burst_scheduler.sv | 152 +++++++++++++++
 tb/tb_bram_burst_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_burst_scheduler_pkg.sv
// Shared definitions for the BRAM burst scheduler: FSM encoding and default widths.
package bram_burst_scheduler_pkg;

  localparam int unsigned DefaultAddrW = 16;

  localparam logic [1:0] StateIdle = 2'd0;
  localparam logic [1:0] StateLoad = 2'd1;
  localparam logic [1:0] StateRun  = 2'd2;
  localparam logic [1:0] StateDone = 2'd3;

  typedef enum logic [1:0] {
    StIdle = StateIdle,
    StLoad = StateLoad,
    StRun  = StateRun,
    StDone = StateDone
  } state_e;

endpackage

// File: rtl/axis_counter.sv
// Generic loadable up-counter: start loads the base value, done once limit increments have occurred.
module axis_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             counter_start,
  input  logic             counter_enable,
  input  logic [WIDTH-1:0] start_addr,
  input  logic [WIDTH-1:0] count_limit,
  output logic [WIDTH-1:0] counter,
  output logic             counter_done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  always_comb begin
    count_d = count_q;
    steps_d = steps_q;
    limit_d = limit_q;
    if (counter_start) begin
      count_d = start_addr;
      steps_d = '0;
      limit_d = count_limit;
    end else if (counter_enable) begin
      count_d = count_q + WIDTH'(1);
      steps_d = steps_q + WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q <= '0;
      steps_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      steps_q <= steps_d;
      limit_q <= limit_d;
    end
  end

  assign counter      = count_q;
  assign counter_done = (steps_q == limit_q);

endmodule

// File: rtl/bram_burst_scheduler.sv
// Round-robin arbiter that hands one shared BRAM address counter to one burst requester at a time.
module bram_burst_scheduler
  import bram_burst_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_start_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_len,
  input  logic                      stall,
  output logic                      bram_en,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic                      burst_last,
  output logic [IdW-1:0]            grant_id,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      busy
);

  state_e             state_q, state_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0]  issued_q, issued_d;
  logic [IdW-1:0]     winner;
  logic [ADDR_W-1:0]  sel_start, sel_len;
  logic               counter_start, counter_enable, counter_done;
  logic [ADDR_W-1:0]  counter;

  // First valid index at or after ptr; otherwise the lowest valid index (wrap-around).
  function automatic logic [IdW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IdW-1:0]     ptr);
    logic [IdW-1:0] any_pick;
    logic [IdW-1:0] hi_pick;
    logic           hi_found;
    any_pick = '0;
    hi_pick  = '0;
    hi_found = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        any_pick = IdW'(i);
        if (i >= int'(ptr)) begin
          hi_pick  = IdW'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi_pick : any_pick;
  endfunction

  always_comb begin
    winner    = rr_pick(req_valid, rr_ptr_q);
    sel_start = '0;
    sel_len   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == IdW'(i)) begin
        sel_start = req_start_addr[i*ADDR_W +: ADDR_W];
        sel_len   = req_len[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    start_d       = start_q;
    len_d         = len_q;
    issued_d      = issued_q;
    req_ready     = '0;
    req_done      = '0;
    counter_start = 1'b0;
    bram_en       = 1'b0;
    burst_last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready = NUM_REQ'(1) << winner;
          grant_d   = winner;
          start_d   = sel_start;
          len_d     = sel_len;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        counter_start = 1'b1;
        issued_d      = '0;
        state_d       = (len_q != '0) ? StRun : StDone;
      end
      StRun: begin
        bram_en = !stall && !counter_done;
        if (bram_en) begin
          issued_d = issued_q + ADDR_W'(1);
          // Own word count keeps burst_last independent of the counter's done timing.
          if (issued_q == len_q - ADDR_W'(1)) begin
            burst_last = 1'b1;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        req_done = NUM_REQ'(1) << grant_q;
        rr_ptr_d = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + IdW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign counter_enable = bram_en;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      start_q  <= start_d;
      len_q    <= len_d;
      issued_q <= issued_d;
    end
  end

  axis_counter #(
    .WIDTH (ADDR_W)
  ) u_addr_counter (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .counter_start  (counter_start),
    .counter_enable (counter_enable),
    .start_addr     (start_q),
    .count_limit    (len_q),
    .counter        (counter),
    .counter_done   (counter_done)
  );

  assign bram_addr = counter;
  assign grant_id  = grant_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bram_burst_scheduler.sv
// Directed bench for bram_burst_scheduler: burst table plus contention and mid-burst reset sequences.
module tb_bram_burst_scheduler;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_start_addr;
  logic [NR*AW-1:0]  req_len;
  logic              stall;
  logic              bram_en;
  logic [AW-1:0]     bram_addr;
  logic              burst_last;
  logic [1:0]        grant_id;
  logic [NR-1:0]     req_done;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  bram_burst_scheduler #(
    .NUM_REQ (NR),
    .ADDR_W  (AW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_start_addr (req_start_addr),
    .req_len        (req_len),
    .stall          (stall),
    .bram_en        (bram_en),
    .bram_addr      (bram_addr),
    .burst_last     (burst_last),
    .grant_id       (grant_id),
    .req_done       (req_done),
    .busy           (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] start;
    logic [15:0] len;
    logic [31:0] smask;   // bit c = stall during cycle t0+c
    int          done_c;  // expected req_done cycle relative to acceptance
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic run_burst(input int id, input logic [15:0] start, input logic [15:0] len,
                           input logic [31:0] smask, input int exp_done);
    int          n;
    bit          acc;
    bit          got;
    logic [15:0] ea;
    req_start_addr[id*AW +: AW] = start;
    req_len[id*AW +: AW]        = len;
    req_valid[id]               = 1'b1;
    acc = 1'b0;
    for (int w = 0; w < 10 && !acc; w++) begin
      #1;
      if (req_ready[id]) acc = 1'b1;
      else tick();
    end
    if (!acc) begin
      req_valid[id] = 1'b0;
      timeout("accept");
      return;
    end
    chk("ready_onehot", 32'(req_ready), 32'(1) << id);
    tick();
    req_valid[id] = 1'b0;
    n   = 0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      stall = (c < 32) ? smask[c] : 1'b0;
      #1;
      if (c == 1) begin
        chk("busy_load", 32'(busy), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(id));
      end
      ea = start + 16'(n);
      if (bram_en) begin
        chk("addr", 32'(bram_addr), 32'(ea));
        chk("last", 32'(burst_last), 32'(n == int'(len) - 1));
        n++;
      end else if (n > 0 && n < int'(len)) begin
        chk("hold_addr", 32'(bram_addr), 32'(ea));
      end
      if (req_done != '0) begin
        chk("done_vec", 32'(req_done), 32'(1) << id);
        chk("done_cycle", 32'(c), 32'(exp_done));
        got = 1'b1;
      end
      tick();
    end
    stall = 1'b0;
    if (!got) timeout("req_done");
    chk("issued_words", 32'(n), 32'(len));
  endtask

  task automatic serve(input int exp);
    bit acc;
    bit got;
    acc = 1'b0;
    for (int w = 0; w < 10 && !acc; w++) begin
      #1;
      if (req_ready != '0) acc = 1'b1;
      else tick();
    end
    if (!acc) begin
      timeout("rr_accept");
      return;
    end
    chk("rr_grant", 32'(req_ready), 32'(1) << exp);
    tick();
    req_valid[exp] = 1'b0;
    #1;
    chk("rr_grant_id", 32'(grant_id), 32'(exp));
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (req_done != '0) begin
        chk("rr_done", 32'(req_done), 32'(1) << exp);
        got = 1'b1;
      end
      tick();
    end
    if (!got) timeout("rr_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 16'd256,   16'd4, 32'h0,  6};  // plain burst
    vecs[1] = '{1, 16'd10,    16'd3, 32'h18, 7};  // 2 stall cycles after first address
    vecs[2] = '{2, 16'hFFFE,  16'd3, 32'h0,  5};  // address wrap
    vecs[3] = '{1, 16'd100,   16'd0, 32'h0,  2};  // zero length
    vecs[4] = '{2, 16'h0040,  16'd1, 32'h2,  3};  // stall during LOAD ignored
    vecs[5] = '{0, 16'd5,     16'd2, 32'h10, 4};  // stall during DONE ignored

    aresetn        = 1'b0;
    req_valid      = '0;
    req_start_addr = '0;
    req_len        = '0;
    stall          = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    aresetn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].id, vecs[v].start, vecs[v].len, vecs[v].smask, vecs[v].done_c);
    end

    // Contention: full round after pointer reset, then req 2 and req 0 together.
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      req_start_addr[i*AW +: AW] = 16'(i * 256);
      req_len[i*AW +: AW]        = 16'd2;
    end
    req_valid = 3'b111;
    serve(0);
    serve(1);
    serve(2);
    req_valid = 3'b101;
    serve(0);
    serve(2);

    // Reset on the second RUN cycle of a len-8 burst.
    req_start_addr[0 +: AW] = 16'h0200;
    req_len[0 +: AW]        = 16'd8;
    req_valid[0]            = 1'b1;
    #1;
    chk("mid_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_run_en", 32'(bram_en), 32'd1);
    chk("mid_run_addr", 32'(bram_addr), 32'h201);
    aresetn = 1'b0;
    tick();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'(bram_en), 32'd0);
    chk("abort_addr", 32'(bram_addr), 32'd0);
    chk("abort_last", 32'(burst_last), 32'd0);
    chk("abort_done", 32'(req_done), 32'd0);
    chk("abort_grant", 32'(grant_id), 32'd0);
    aresetn = 1'b1;
    for (int w = 0; w < 4; w++) begin
      tick();
      #1;
      chk("abort_no_done", 32'(req_done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    run_burst(2, 16'd7, 16'd2, 32'h0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
